jtdd2_dwnld: RTL

JTDD2_DWNLD -- requirements
Module: jtdd2_dwnld

---
 rtl/jtdd2_dwnld.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/jtdd2_dwnld.sv
// ROM download router: maps ioctl bytes onto SDRAM lanes or PROM BRAM,
// and stretches a busy flag for a short tail after the download ends.
module jtdd2_dwnld #(
  parameter logic [21:0] SCRZW_ADDR = 22'h90000,
  parameter logic [21:0] SCRXY_ADDR = 22'hB0000,
  parameter logic [21:0] OBJWZ_ADDR = 22'hD0000,
  parameter logic [21:0] OBJXY_ADDR = 22'h130000,
  parameter logic [21:0] PROM_ADDR  = 22'h190000,
  parameter logic [21:0] PROM_END   = 22'h190200,
  parameter logic [21:0] SCR_SDRAM  = 22'h60000,
  parameter logic [21:0] OBJ_SDRAM  = 22'h80000,
  parameter int          TAIL       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        downloading,
  input  logic [21:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic        prog_we,
  output logic        prom_we,
  output logic        dwnld_busy,
  output logic        addr_err
);

  localparam int CW = $clog2(TAIL) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TAIL
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [21:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  mask_q, mask_d;
  logic        pwe_q, pwe_d;
  logic        rwe_q, rwe_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;

  logic        wr_ok;
  logic [21:0] a;
  logic [21:0] off_zw, off_xy, off_wz, off_oxy, off_pr;

  assign a       = ioctl_addr;
  assign wr_ok   = ioctl_wr & downloading;
  assign off_zw  = a - SCRZW_ADDR;
  assign off_xy  = a - SCRXY_ADDR;
  assign off_wz  = a - OBJWZ_ADDR;
  assign off_oxy = a - OBJXY_ADDR;
  assign off_pr  = a - PROM_ADDR;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (downloading) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (!downloading) begin
          state_d = ST_TAIL;
          cnt_d   = '0;
        end
      end
      ST_TAIL: begin
        if (downloading) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end else if (cnt_q == CW'(TAIL - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    mask_d = mask_q;
    pwe_d  = 1'b0;
    rwe_d  = 1'b0;
    if (wr_ok) begin
      unique case (1'b1)
        (a < SCRZW_ADDR): begin
          addr_d = {1'b0, a[21:1]};
          mask_d = a[0] ? 2'b01 : 2'b10;
          pwe_d  = 1'b1;
        end
        (a >= SCRZW_ADDR && a < SCRXY_ADDR): begin
          addr_d = SCR_SDRAM + {5'd0, off_zw[16:0]};
          mask_d = 2'b10;
          pwe_d  = 1'b1;
        end
        (a >= SCRXY_ADDR && a < OBJWZ_ADDR): begin
          addr_d = SCR_SDRAM + {5'd0, off_xy[16:0]};
          mask_d = 2'b01;
          pwe_d  = 1'b1;
        end
        (a >= OBJWZ_ADDR && a < OBJXY_ADDR): begin
          addr_d = OBJ_SDRAM + {3'd0, off_wz[18:0]};
          mask_d = 2'b10;
          pwe_d  = 1'b1;
        end
        (a >= OBJXY_ADDR && a < PROM_ADDR): begin
          addr_d = OBJ_SDRAM + {3'd0, off_oxy[18:0]};
          mask_d = 2'b01;
          pwe_d  = 1'b1;
        end
        (a >= PROM_ADDR && a < PROM_END): begin
          addr_d = off_pr;
          mask_d = 2'b11;
          rwe_d  = 1'b1;
        end
        default: ;
      endcase
      if (pwe_d || rwe_d) data_d = ioctl_data;
    end
  end

  // An out-of-range byte wins over the clear on download start.
  logic err_n;
  assign err_n = err_d | (wr_ok & (a >= PROM_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= 2'b11;
      pwe_q   <= 1'b0;
      rwe_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      pwe_q   <= pwe_d;
      rwe_q   <= rwe_d;
      err_q   <= err_n;
      busy_q  <= busy_d;
    end
  end

  assign prog_addr  = addr_q;
  assign prog_data  = data_q;
  assign prog_mask  = mask_q;
  assign prog_we    = pwe_q;
  assign prom_we    = rwe_q;
  assign addr_err   = err_q;
  assign dwnld_busy = busy_q;

endmodule
